// File: rtl/mmio_decoder.sv
// Purpose: decodes CPU data-port accesses onto a data RAM and a bank of NUM_IO IO registers.
// Latency: req -> ready is W+2 cycles (W = RAM_WAIT, IO_WAIT, or 0 when unmapped); write strobe in cycle W+1.
// Backpressure: one access in flight; req is sampled only in IDLE and ignored while busy, nothing is queued.
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   req, load, address  request strobe, 1=write/0=read, CPU address (all sampled together in IDLE)
//   rdata, ready, err   response data, one-cycle response pulse, unmapped-address flag (only with ready)
//   busy                high from the cycle after an accepted req through the ready cycle
//   loadRAM, loadIO     registered one-cycle write strobes (loadIO one-hot, bit i = IO_BASE+i)
//   inRAM, inIO         device read data; IO channel i at inIO[i*WIDTH +: WIDTH]
module mmio_decoder #(
    parameter int WIDTH     = 16,
    parameter int RAM_DEPTH = 3840,
    parameter int IO_BASE   = 4096,
    parameter int NUM_IO    = 16,
    parameter int RAM_WAIT  = 0,
    parameter int IO_WAIT   = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req,
    input  logic                    load,
    input  logic [WIDTH-1:0]        address,
    output logic [WIDTH-1:0]        rdata,
    output logic                    ready,
    output logic                    err,
    output logic                    busy,
    output logic                    loadRAM,
    output logic [NUM_IO-1:0]       loadIO,
    input  logic [WIDTH-1:0]        inRAM,
    input  logic [NUM_IO*WIDTH-1:0] inIO
);

    localparam int IDXW = (NUM_IO > 1) ? $clog2(NUM_IO) : 1;

    // One extra bit so IO_BASE+NUM_IO == 2^WIDTH and RAM_DEPTH == 2^WIDTH stay representable.
    localparam logic [WIDTH:0] IO_LO  = (WIDTH+1)'(IO_BASE);
    localparam logic [WIDTH:0] IO_N   = (WIDTH+1)'(NUM_IO);
    localparam logic [WIDTH:0] RAM_HI = (WIDTH+1)'(RAM_DEPTH);

    generate
        if (longint'(IO_BASE) + longint'(NUM_IO) > (longint'(1) << WIDTH)) begin : g_chk_io_range
            $error("mmio_decoder: IO_BASE+NUM_IO exceeds the address space");
        end
        if (longint'(RAM_DEPTH) > (longint'(1) << WIDTH)) begin : g_chk_ram_range
            $error("mmio_decoder: RAM_DEPTH exceeds the address space");
        end
        if (NUM_IO < 1 || NUM_IO > 64) begin : g_chk_num_io
            $error("mmio_decoder: NUM_IO must be 1..64");
        end
        if (RAM_WAIT < 0 || RAM_WAIT > 15 || IO_WAIT < 0 || IO_WAIT > 15) begin : g_chk_wait
            $error("mmio_decoder: wait states must be 0..15");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t            state;
    logic [3:0]        cnt;
    logic              load_q;
    logic              io_q;
    logic              ram_q;
    logic [IDXW-1:0]   idx_q;

    // Live decode of the incoming address (used only when a req is accepted).
    logic [WIDTH:0]    addr_x;
    logic [WIDTH:0]    io_off;
    logic              io_hit;
    logic              ram_hit;
    logic [IDXW-1:0]   io_idx;
    logic [3:0]        wait_init;

    assign addr_x    = {1'b0, address};
    assign io_off    = addr_x - IO_LO;
    assign io_hit    = (addr_x >= IO_LO) && (io_off < IO_N);
    // IO wins on overlap, so an address inside the IO window never reaches the RAM.
    assign ram_hit   = !io_hit && (addr_x < RAM_HI);
    assign io_idx    = io_off[IDXW-1:0];
    assign wait_init = io_hit ? 4'(IO_WAIT) : (ram_hit ? 4'(RAM_WAIT) : 4'd0);

    // The strobe for the ACCESS cycle is registered on the edge that enters ACCESS.
    // From IDLE (zero wait) that edge is also the accept edge, so the live decode is used;
    // from WAIT the latched decode is used.
    logic              sel_load;
    logic              sel_io;
    logic              sel_ram;
    logic [IDXW-1:0]   sel_idx;
    logic [NUM_IO-1:0] io_onehot;
    logic              strobe_ram;
    logic [NUM_IO-1:0] strobe_io;

    always_comb begin
        if (state == IDLE) begin
            sel_load = load;
            sel_io   = io_hit;
            sel_ram  = ram_hit;
            sel_idx  = io_idx;
        end else begin
            sel_load = load_q;
            sel_io   = io_q;
            sel_ram  = ram_q;
            sel_idx  = idx_q;
        end
    end

    always_comb begin
        io_onehot = '0;
        for (int i = 0; i < NUM_IO; i++) begin
            io_onehot[i] = (sel_idx == IDXW'(i));
        end
    end

    assign strobe_ram = sel_load && sel_ram;
    assign strobe_io  = (sel_load && sel_io) ? io_onehot : '0;

    // Read mux over the latched channel index.
    logic [WIDTH-1:0]  io_word;

    always_comb begin
        io_word = '0;
        for (int i = 0; i < NUM_IO; i++) begin
            if (idx_q == IDXW'(i)) begin
                io_word = inIO[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            load_q  <= 1'b0;
            io_q    <= 1'b0;
            ram_q   <= 1'b0;
            idx_q   <= '0;
            rdata   <= '0;
            ready   <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b0;
            loadRAM <= 1'b0;
            loadIO  <= '0;
        end else begin
            // Pulsed outputs default low so each is exactly one cycle wide.
            ready   <= 1'b0;
            err     <= 1'b0;
            loadRAM <= 1'b0;
            loadIO  <= '0;
            case (state)
                IDLE: begin
                    if (req) begin
                        load_q <= load;
                        io_q   <= io_hit;
                        ram_q  <= ram_hit;
                        idx_q  <= io_idx;
                        cnt    <= wait_init;
                        busy   <= 1'b1;
                        if (wait_init != 4'd0) begin
                            state <= WAIT;
                        end else begin
                            state   <= ACCESS;
                            loadRAM <= strobe_ram;
                            loadIO  <= strobe_io;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state   <= ACCESS;
                        loadRAM <= strobe_ram;
                        loadIO  <= strobe_io;
                    end
                end
                ACCESS: begin
                    // Captured for reads and writes alike; unmapped returns zero.
                    if (io_q) begin
                        rdata <= io_word;
                    end else if (ram_q) begin
                        rdata <= inRAM;
                    end else begin
                        rdata <= '0;
                    end
                    ready <= 1'b1;
                    err   <= !(io_q || ram_q);
                    state <= RESP;
                end
                RESP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_decoder.sv
// Purpose: directed self-checking bench for mmio_decoder across three parameter sets.
// Latency: each transaction is followed until its ready pulse (bounded cycle budget).
// Backpressure: stimulus issues one request at a time and waits for IDLE before the next.
module tb_mmio_decoder;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [2:0]  req_s;
    logic [2:0]  load_s;
    logic [15:0] addr_s [3];

    // Instance a: default parameters.
    logic [15:0]  a_rdata, a_inRAM, a_loadIO;
    logic         a_ready, a_err, a_busy, a_loadRAM;
    logic [255:0] a_inIO;
    // Instance b: IO window overlapping RAM, long IO wait.
    logic [15:0]  b_rdata, b_inRAM, b_loadIO;
    logic         b_ready, b_err, b_busy, b_loadRAM;
    logic [255:0] b_inIO;
    // Instance c: narrow bus, 4 IO channels, RAM wait of 2.
    logic [11:0]  c_rdata, c_inRAM;
    logic [3:0]   c_loadIO;
    logic         c_ready, c_err, c_busy, c_loadRAM;
    logic [47:0]  c_inIO;

    mmio_decoder u_a (
        .clk(clk), .reset(reset), .req(req_s[0]), .load(load_s[0]), .address(addr_s[0]),
        .rdata(a_rdata), .ready(a_ready), .err(a_err), .busy(a_busy),
        .loadRAM(a_loadRAM), .loadIO(a_loadIO), .inRAM(a_inRAM), .inIO(a_inIO)
    );

    mmio_decoder #(.IO_BASE(2048), .IO_WAIT(3)) u_b (
        .clk(clk), .reset(reset), .req(req_s[1]), .load(load_s[1]), .address(addr_s[1]),
        .rdata(b_rdata), .ready(b_ready), .err(b_err), .busy(b_busy),
        .loadRAM(b_loadRAM), .loadIO(b_loadIO), .inRAM(b_inRAM), .inIO(b_inIO)
    );

    mmio_decoder #(.WIDTH(12), .RAM_DEPTH(3000), .IO_BASE(4000), .NUM_IO(4), .RAM_WAIT(2)) u_c (
        .clk(clk), .reset(reset), .req(req_s[2]), .load(load_s[2]), .address(addr_s[2][11:0]),
        .rdata(c_rdata), .ready(c_ready), .err(c_err), .busy(c_busy),
        .loadRAM(c_loadRAM), .loadIO(c_loadIO), .inRAM(c_inRAM), .inIO(c_inIO)
    );

    // View of the currently selected instance; v_strb[16] = loadRAM, [15:0] = loadIO.
    int          cur = 0;
    logic        v_ready, v_err, v_busy;
    logic [15:0] v_rdata;
    logic [16:0] v_strb;

    always_comb begin
        v_ready = 1'b0; v_err = 1'b0; v_busy = 1'b0; v_rdata = '0; v_strb = '0;
        case (cur)
            0: begin v_ready = a_ready; v_err = a_err; v_busy = a_busy; v_rdata = a_rdata; v_strb = {a_loadRAM, a_loadIO}; end
            1: begin v_ready = b_ready; v_err = b_err; v_busy = b_busy; v_rdata = b_rdata; v_strb = {b_loadRAM, b_loadIO}; end
            2: begin v_ready = c_ready; v_err = c_err; v_busy = c_busy; v_rdata = {4'h0, c_rdata}; v_strb = {c_loadRAM, 12'h000, c_loadIO}; end
            default: ;
        endcase
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // err must never be seen without ready.
    int errx = 0;
    always @(negedge clk) begin
        if ((a_err && !a_ready) || (b_err && !b_ready) || (c_err && !c_ready)) errx++;
    end

    // Observations of one transaction.
    int          scyc, scnt, rcyc;
    logic [16:0] strb;
    logic [15:0] rd;
    logic        er;

    function automatic logic [63:0] pack(input int sc, input int sn, input int rc, input logic e,
                                         input logic [16:0] s, input logic [15:0] r);
        return {10'h0, 8'(sc), 4'(sn), 8'(rc), e, s, r};
    endfunction

    // Called #1 after an edge with the DUT idle; cycle 1 is the cycle after the accept edge.
    task automatic txn(input int sel, input logic ld, input logic [15:0] ad);
        cur = sel;
        req_s[sel] = 1'b1; load_s[sel] = ld; addr_s[sel] = ad;
        @(posedge clk); #1;
        req_s[sel] = 1'b0;
        scyc = -1; scnt = 0; rcyc = -1; strb = '0; rd = '0; er = 1'b0;
        for (int c = 1; c <= 24; c++) begin
            if (v_strb != '0) begin
                if (scyc < 0) scyc = c;
                scnt++;
                strb |= v_strb;
            end
            if (v_ready) begin
                rcyc = c; rd = v_rdata; er = v_err;
            end
            @(posedge clk); #1;
            if (rcyc >= 0) break;
        end
    endtask

    logic [15:0] io_val [16];
    logic [16:0] exp_s;
    logic [15:0] exp_r;
    int          exp_sc, exp_sn, exp_rc, seen;
    logic        exp_e;

    initial begin
        #3_000_000;
        $display("FAIL watchdog_timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        req_s = 3'b111; load_s = 3'b111;
        for (int i = 0; i < 3; i++) addr_s[i] = 16'd100;
        for (int i = 0; i < 16; i++) begin
            io_val[i] = 16'($urandom);
            a_inIO[i*16 +: 16] = io_val[i];
        end
        a_inRAM = 16'h0042;
        b_inRAM = 16'h0000; b_inIO = '0;
        c_inRAM = 12'h5A5;  c_inIO = {12'h103, 12'h102, 12'h101, 12'h100};

        // Reset held with req high, then released with req low.
        repeat (2) @(posedge clk);
        #1;
        check("rst_a", {v_ready, v_err, v_busy, v_rdata, v_strb}, 64'h0);
        check("rst_b", {b_ready, b_err, b_busy, b_rdata, b_loadRAM, b_loadIO}, 64'h0);
        check("rst_c", {c_ready, c_err, c_busy, c_rdata, c_loadRAM, c_loadIO}, 64'h0);
        reset = 1'b0; req_s = 3'b000;
        repeat (3) @(posedge clk);
        #1;
        check("idle_a", {v_ready, v_err, v_busy, v_rdata, v_strb}, 64'h0);

        // RAM write and read, zero wait.
        txn(0, 1'b1, 16'd100);
        check("ram_wr", pack(scyc, scnt, rcyc, er, strb, rd), pack(1, 1, 2, 1'b0, 17'h10000, 16'h0042));
        a_inRAM = 16'hBEEF;
        txn(0, 1'b0, 16'd3839);
        check("ram_rd_top", pack(scyc, scnt, rcyc, er, strb, rd), pack(-1, 0, 2, 1'b0, 17'h0, 16'hBEEF));
        a_inRAM = 16'h1234;
        @(posedge clk); #1;
        check("rdata_hold", 64'(a_rdata), 64'hBEEF);

        // All 16 IO channels, write then read, IO_WAIT=1.
        for (int i = 0; i < 16; i++) begin
            txn(0, 1'b1, 16'(4096 + i));
            check($sformatf("io_wr_%0d", i), pack(scyc, scnt, rcyc, er, strb, rd),
                  pack(2, 1, 3, 1'b0, 17'h1 << i, io_val[i]));
            txn(0, 1'b0, 16'(4096 + i));
            check($sformatf("io_rd_%0d", i), pack(scyc, scnt, rcyc, er, strb, rd),
                  pack(-1, 0, 3, 1'b0, 17'h0, io_val[i]));
        end

        // Unmapped: gap above RAM and just past the IO window.
        txn(0, 1'b1, 16'd3840);
        check("unmap_3840", pack(scyc, scnt, rcyc, er, strb, rd), pack(-1, 0, 2, 1'b1, 17'h0, 16'h0));
        txn(0, 1'b0, 16'd4112);
        check("unmap_4112", pack(scyc, scnt, rcyc, er, strb, rd), pack(-1, 0, 2, 1'b1, 17'h0, 16'h0));

        // req held while busy is ignored: exactly one ready, one IO strobe.
        cur = 0;
        req_s[0] = 1'b1; load_s[0] = 1'b1; addr_s[0] = 16'd4100;
        @(posedge clk); #1;
        check("busy_after_req", 64'(v_busy), 64'h1);
        addr_s[0] = 16'd100;
        seen = 0; exp_s = '0;
        for (int c = 1; c <= 10; c++) begin
            if (c == 3) begin
                req_s[0] = 1'b0;
                check("busy_with_ready", {62'h0, v_busy, v_ready}, 64'h3);
            end
            if (v_ready) seen++;
            exp_s |= v_strb;
            @(posedge clk); #1;
        end
        check("busy_one_ready", 64'(seen), 64'h1);
        check("busy_one_strobe", 64'(exp_s), 64'h00010);
        check("busy_low_after", 64'(v_busy), 64'h0);

        // Overlapping IO window: IO wins, RAM below still works.
        txn(1, 1'b1, 16'd2048);
        check("ovl_io0", pack(scyc, scnt, rcyc, er, strb, rd), pack(4, 1, 5, 1'b0, 17'h00001, 16'h0));
        txn(1, 1'b1, 16'd2063);
        check("ovl_io15", pack(scyc, scnt, rcyc, er, strb, rd), pack(4, 1, 5, 1'b0, 17'h08000, 16'h0));
        txn(1, 1'b1, 16'd100);
        check("b_ram_wr", pack(scyc, scnt, rcyc, er, strb, rd), pack(1, 1, 2, 1'b0, 17'h10000, 16'h0));

        // Reset during WAIT aborts the access; a fresh request then completes.
        cur = 1;
        req_s[1] = 1'b1; load_s[1] = 1'b1; addr_s[1] = 16'd2050;
        @(posedge clk); #1;
        req_s[1] = 1'b0;
        check("b_busy_wait", 64'(v_busy), 64'h1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("b_busy_cleared", 64'(v_busy), 64'h0);
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            if (v_ready || v_strb != '0) seen++;
            @(posedge clk); #1;
        end
        check("abort_quiet", 64'(seen), 64'h0);
        txn(1, 1'b1, 16'd2050);
        check("after_abort", pack(scyc, scnt, rcyc, er, strb, rd), pack(4, 1, 5, 1'b0, 17'h00004, 16'h0));

        // Narrow instance: RAM latency, then full address sweep against the decode model.
        txn(2, 1'b0, 16'd0);
        check("c_ram_lat", 64'(rcyc), 64'd4);
        for (int a = 0; a < 4096; a++) begin
            exp_e = 1'b0; exp_s = '0; exp_sc = -1; exp_sn = 0;
            if (a >= 4000 && a < 4004) begin
                exp_rc = 3; exp_r = 16'(12'h100 + (a - 4000));
                if (a[0]) begin exp_s = 17'h1 << (a - 4000); exp_sc = 2; exp_sn = 1; end
            end else if (a < 3000) begin
                exp_rc = 4; exp_r = 16'h05A5;
                if (a[0]) begin exp_s = 17'h10000; exp_sc = 3; exp_sn = 1; end
            end else begin
                exp_rc = 2; exp_r = 16'h0; exp_e = 1'b1;
            end
            txn(2, a[0], 16'(a));
            check($sformatf("sweep_%0d", a), pack(scyc, scnt, rcyc, er, strb, rd),
                  pack(exp_sc, exp_sn, exp_rc, exp_e, exp_s, exp_r));
        end

        check("err_only_with_ready", 64'(errx), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
